// File: rtl/mem_port_arbiter.sv
// Shares one data-bus port between the page-table walker, the memory stage and fetch.
// Optional build macro MEM_ARB_RR_EN: round-robin between mem and fetch (ptw stays highest).
package common;
    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;
endpackage

module mem_port_arbiter
    import common::*;
(
    input  logic       clk,
    input  logic       reset,
    input  dbus_req_t  ptw_req,
    output dbus_resp_t ptw_resp,
    input  dbus_req_t  mem_req,
    output dbus_resp_t mem_resp,
    input  ibus_req_t  if_req,
    output ibus_resp_t if_resp,
    output dbus_req_t  dreq,
    input  dbus_resp_t dresp,
    output logic [2:0] grant,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t     state_reg;
    logic [2:0] grant_reg;
    logic [2:0] valids;
    logic [2:0] winner;
    logic       granted_valid;
    logic       resp_en;
    dbus_req_t  fetch_dreq;

    assign valids = {if_req.valid, mem_req.valid, ptw_req.valid};

`ifdef MEM_ARB_RR_EN
    // Set when fetch won the last mem/fetch arbitration; reset value makes mem win first.
    logic last_fetch_reg;

    always_comb begin
        winner = 3'b000;
        if (valids[0])
            winner = 3'b001;
        else if (valids[1] && valids[2])
            winner = last_fetch_reg ? 3'b010 : 3'b100;
        else if (valids[1])
            winner = 3'b010;
        else if (valids[2])
            winner = 3'b100;
    end

    always_ff @(posedge clk) begin
        if (reset)
            last_fetch_reg <= 1'b1;
        else if (state_reg == IDLE && (winner[1] || winner[2]))
            last_fetch_reg <= winner[2];
    end
`else
    always_comb begin
        winner = 3'b000;
        if (valids[0])
            winner = 3'b001;
        else if (valids[1])
            winner = 3'b010;
        else if (valids[2])
            winner = 3'b100;
    end
`endif

    assign granted_valid = |(grant_reg & valids);

    always_comb begin
        fetch_dreq        = '0;
        fetch_dreq.valid  = if_req.valid;
        fetch_dreq.addr   = if_req.addr;
        fetch_dreq.size   = MSIZE4;
    end

    // grant_reg is zero in IDLE, so dreq falls back to all-zero there.
    always_comb begin
        dreq = '0;
        unique case (grant_reg)
            3'b001:  dreq = ptw_req;
            3'b010:  dreq = mem_req;
            3'b100:  dreq = fetch_dreq;
            default: dreq = '0;
        endcase
    end

    // An aborting requester sees nothing even if the bus answers in that cycle.
    assign resp_en = (state_reg == DATA) || (state_reg == ADDR && granted_valid);

    always_comb begin
        ptw_resp = '0;
        mem_resp = '0;
        if_resp  = '0;
        if (resp_en && grant_reg[0])
            ptw_resp = dresp;
        if (resp_en && grant_reg[1])
            mem_resp = dresp;
        if (resp_en && grant_reg[2]) begin
            if_resp.addr_ok = dresp.addr_ok;
            if_resp.data_ok = dresp.data_ok;
            if_resp.data    = if_req.addr[2] ? dresp.data[63:32] : dresp.data[31:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            grant_reg <= 3'b000;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (|valids) begin
                        grant_reg <= winner;
                        state_reg <= ADDR;
                    end
                end
                ADDR: begin
                    if (!granted_valid || (dresp.addr_ok && dresp.data_ok)) begin
                        grant_reg <= 3'b000;
                        state_reg <= IDLE;
                    end else if (dresp.addr_ok) begin
                        state_reg <= DATA;
                    end
                end
                DATA: begin
                    if (dresp.data_ok) begin
                        grant_reg <= 3'b000;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    grant_reg <= 3'b000;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign grant = grant_reg;
    assign busy  = (state_reg != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: cycle table plus abort, reset and starvation sequences.
module tb_mem_port_arbiter;
    import common::*;

    logic       clk = 1'b0;
    logic       reset;
    dbus_req_t  ptw_req, mem_req, dreq;
    dbus_resp_t ptw_resp, mem_resp, dresp;
    ibus_req_t  if_req;
    ibus_resp_t if_resp;
    logic [2:0] grant;
    logic       busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .ptw_req  (ptw_req),
        .ptw_resp (ptw_resp),
        .mem_req  (mem_req),
        .mem_resp (mem_resp),
        .if_req   (if_req),
        .if_resp  (if_resp),
        .dreq     (dreq),
        .dresp    (dresp),
        .grant    (grant),
        .busy     (busy)
    );

    // One row per clock cycle; valids are {fetch, mem, ptw}, expected responses likewise.
    typedef struct {
        logic [2:0]  vld;
        logic        aok;
        logic        dok;
        logic [63:0] rdata;
        logic [2:0]  e_grant;
        logic        e_busy;
        logic        e_dv;
        logic [63:0] e_daddr;
        logic [2:0]  e_dsize;
        logic [2:0]  e_aok;
        logic [2:0]  e_dok;
        logic [63:0] e_pd;
        logic [63:0] e_md;
        logic [31:0] e_id;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_valids(input logic [2:0] v);
        ptw_req.valid = v[0];
        mem_req.valid = v[1];
        if_req.valid  = v[2];
    endtask

    task automatic set_dresp(input logic aok, input logic dok, input logic [63:0] d);
        dresp.addr_ok = aok;
        dresp.data_ok = dok;
        dresp.data    = d;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    logic [2:0] starve_exp[4];

    initial begin
        ptw_req = '{valid: 1'b0, addr: 64'h1000, size: MSIZE8, strobe: 8'h00, data: 64'h0};
        mem_req = '{valid: 1'b0, addr: 64'h2000, size: MSIZE8, strobe: 8'hFF, data: 64'hDEAD_BEEF};
        if_req  = '{valid: 1'b0, addr: 64'h8000_0004};
        dresp   = '0;
        reset   = 1'b1;

        //         vld     aok   dok   rdata                     grant   busy dv   daddr              sz    aok     dok     pd                        md                        id
        vecs[0]  = '{3'b000, 1'b0, 1'b0, 64'h0,                  3'b000, 1'b0, 1'b0, 64'h0,           3'd0, 3'b000, 3'b000, 64'h0,                    64'h0,                    32'h0};
        vecs[1]  = '{3'b100, 1'b0, 1'b0, 64'h0,                  3'b000, 1'b0, 1'b0, 64'h0,           3'd0, 3'b000, 3'b000, 64'h0,                    64'h0,                    32'h0};
        vecs[2]  = '{3'b100, 1'b0, 1'b0, 64'h0,                  3'b100, 1'b1, 1'b1, 64'h8000_0004,   3'd2, 3'b000, 3'b000, 64'h0,                    64'h0,                    32'h0};
        vecs[3]  = '{3'b100, 1'b1, 1'b0, 64'h0,                  3'b100, 1'b1, 1'b1, 64'h8000_0004,   3'd2, 3'b100, 3'b000, 64'h0,                    64'h0,                    32'h0};
        vecs[4]  = '{3'b100, 1'b0, 1'b1, 64'h1111_2222_3333_4444,3'b100, 1'b1, 1'b1, 64'h8000_0004,   3'd2, 3'b000, 3'b100, 64'h0,                    64'h0,                    32'h1111_2222};
        vecs[5]  = '{3'b000, 1'b0, 1'b0, 64'h0,                  3'b000, 1'b0, 1'b0, 64'h0,           3'd0, 3'b000, 3'b000, 64'h0,                    64'h0,                    32'h0};
        vecs[6]  = '{3'b111, 1'b0, 1'b0, 64'h0,                  3'b000, 1'b0, 1'b0, 64'h0,           3'd0, 3'b000, 3'b000, 64'h0,                    64'h0,                    32'h0};
        vecs[7]  = '{3'b111, 1'b1, 1'b1, 64'hAAAA_BBBB_CCCC_DDDD,3'b001, 1'b1, 1'b1, 64'h1000,        3'd3, 3'b001, 3'b001, 64'hAAAA_BBBB_CCCC_DDDD,64'h0,                    32'h0};
        vecs[8]  = '{3'b110, 1'b0, 1'b0, 64'h0,                  3'b000, 1'b0, 1'b0, 64'h0,           3'd0, 3'b000, 3'b000, 64'h0,                    64'h0,                    32'h0};
        vecs[9]  = '{3'b110, 1'b1, 1'b1, 64'h5555_6666_7777_8888,3'b010, 1'b1, 1'b1, 64'h2000,        3'd3, 3'b010, 3'b010, 64'h0,                    64'h5555_6666_7777_8888,32'h0};
        vecs[10] = '{3'b100, 1'b0, 1'b0, 64'h0,                  3'b000, 1'b0, 1'b0, 64'h0,           3'd0, 3'b000, 3'b000, 64'h0,                    64'h0,                    32'h0};
        vecs[11] = '{3'b100, 1'b1, 1'b1, 64'h7777_8888_9999_AAAA,3'b100, 1'b1, 1'b1, 64'h8000_0004,   3'd2, 3'b100, 3'b100, 64'h0,                    64'h0,                    32'h7777_8888};
        vecs[12] = '{3'b000, 1'b0, 1'b0, 64'h0,                  3'b000, 1'b0, 1'b0, 64'h0,           3'd0, 3'b000, 3'b000, 64'h0,                    64'h0,                    32'h0};

        next_cycle();
        next_cycle();
        reset = 1'b0;

        // Table-driven cycles: single fetch, then ptw/mem/fetch contention.
        for (int i = 0; i < 13; i++) begin
            set_valids(vecs[i].vld);
            set_dresp(vecs[i].aok, vecs[i].dok, vecs[i].rdata);
            @(negedge clk);
            chk($sformatf("v%0d grant", i), 64'(grant), 64'(vecs[i].e_grant));
            chk($sformatf("v%0d busy", i), 64'(busy), 64'(vecs[i].e_busy));
            chk($sformatf("v%0d dreq.valid", i), 64'(dreq.valid), 64'(vecs[i].e_dv));
            if (vecs[i].e_dv) begin
                chk($sformatf("v%0d dreq.addr", i), dreq.addr, vecs[i].e_daddr);
                chk($sformatf("v%0d dreq.size", i), 64'(3'(dreq.size)), 64'(vecs[i].e_dsize));
            end
            if (vecs[i].e_dv && vecs[i].e_grant == 3'b100) begin
                chk($sformatf("v%0d fetch strobe", i), 64'(dreq.strobe), 64'h0);
                chk($sformatf("v%0d fetch wdata", i), dreq.data, 64'h0);
            end
            chk($sformatf("v%0d addr_ok", i), 64'({if_resp.addr_ok, mem_resp.addr_ok, ptw_resp.addr_ok}), 64'(vecs[i].e_aok));
            chk($sformatf("v%0d data_ok", i), 64'({if_resp.data_ok, mem_resp.data_ok, ptw_resp.data_ok}), 64'(vecs[i].e_dok));
            chk($sformatf("v%0d ptw data", i), ptw_resp.data, vecs[i].e_pd);
            chk($sformatf("v%0d mem data", i), mem_resp.data, vecs[i].e_md);
            chk($sformatf("v%0d if data", i), 64'(if_resp.data), 64'(vecs[i].e_id));
            $display("vec %0d: vld=%b grant=%b busy=%b dreq.valid=%b", i, vecs[i].vld, grant, busy, dreq.valid);
            next_cycle();
        end

        // Abort: mem valid drops in ADDR before addr_ok.
        set_valids(3'b010);
        set_dresp(1'b0, 1'b0, 64'h0);
        next_cycle();
        @(negedge clk);
        chk("abort grant in ADDR", 64'(grant), 64'(3'b010));
        chk("abort dreq.valid in ADDR", 64'(dreq.valid), 64'h1);
        #1;
        set_valids(3'b000);
        #1;
        chk("abort dreq.valid dropped", 64'(dreq.valid), 64'h0);
        chk("abort mem_resp", 64'({mem_resp.addr_ok, mem_resp.data_ok}), 64'h0);
        next_cycle();
        @(negedge clk);
        chk("abort grant after", 64'(grant), 64'h0);
        chk("abort busy after", 64'(busy), 64'h0);
        $display("abort: grant=%b busy=%b", grant, busy);
        next_cycle();

        // Reset while in DATA; a late data_ok must be ignored.
        set_valids(3'b010);
        next_cycle();
        set_dresp(1'b1, 1'b0, 64'h0);
        next_cycle();
        set_dresp(1'b0, 1'b0, 64'h0);
        @(negedge clk);
        chk("reset pre busy", 64'(busy), 64'h1);
        chk("reset pre grant", 64'(grant), 64'(3'b010));
        #1;
        reset = 1'b1;
        set_valids(3'b000);
        next_cycle();
        reset = 1'b0;
        set_dresp(1'b0, 1'b1, 64'h1234);
        @(negedge clk);
        chk("reset busy", 64'(busy), 64'h0);
        chk("reset grant", 64'(grant), 64'h0);
        chk("reset dreq.valid", 64'(dreq.valid), 64'h0);
        chk("reset late data_ok", 64'(mem_resp.data_ok), 64'h0);
        next_cycle();
        @(negedge clk);
        chk("reset stays idle", 64'(busy), 64'h0);
        $display("reset: grant=%b busy=%b", grant, busy);
        next_cycle();
        set_dresp(1'b0, 1'b0, 64'h0);

        // Starvation: mem and fetch held valid across four transactions.
`ifdef MEM_ARB_RR_EN
        starve_exp = '{3'b010, 3'b100, 3'b010, 3'b100};
`else
        starve_exp = '{3'b010, 3'b010, 3'b010, 3'b010};
`endif
        set_valids(3'b110);
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            chk($sformatf("starve %0d bubble", t), 64'(busy), 64'h0);
            next_cycle();
            set_dresp(1'b1, 1'b1, 64'h0);
            @(negedge clk);
            chk($sformatf("starve %0d grant", t), 64'(grant), 64'(starve_exp[t]));
            $display("starve txn %0d: grant=%b", t, grant);
            next_cycle();
            set_dresp(1'b0, 1'b0, 64'h0);
        end
        set_valids(3'b000);
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the core's single data-bus port among three requesters: the MMU page-table walker, the memory stage, and instruction fetch. It sits between those requesters and the external `dreq`/`dresp` channel.

- Only one transaction is outstanding at a time.
- Each grant is latched for the whole transaction.
- Handshake responses go only to the granted requester.
- Fetch requests are converted from ibus to dbus format.

## Interface
Parameters:
- None. All widths are fixed by the `common` package types.

Ports (clock and reset: `clk`, `reset`, synchronous, active-high):
- `clk`  in  1  core clock
- `reset`  in  1  synchronous active-high reset
- `ptw_req`  in  dbus_req_t  page-table-walk read (valid, addr[63:0], size, strobe[7:0], data[63:0])
- `ptw_resp`  out  dbus_resp_t  addr_ok, data_ok, data[63:0]
- `mem_req`  in  dbus_req_t  memory-stage load/store
- `mem_resp`  out  dbus_resp_t  response to memory stage
- `if_req`  in  ibus_req_t  fetch (valid, addr[63:0])
- `if_resp`  out  ibus_resp_t  addr_ok, data_ok, data[31:0]
- `dreq`  out  dbus_req_t  external request
- `dresp`  in  dbus_resp_t  external response
- `grant`  out  3  one-hot owner: bit0 = ptw, bit1 = mem, bit2 = fetch; 0 when idle
- `busy`  out  1  state != IDLE

## Operation
- **States:** IDLE, ADDR (request driven, waiting for addr_ok), DATA (addr accepted, waiting for data_ok).
- **IDLE:**
  - If any valid is high, latch the winner into `grant` and go to ADDR.
  - `dreq.valid` = 0 and every response = 0.
- **ADDR / DATA:**
  - `dreq` is a combinational copy of the granted request.
  - For fetch, the arbiter builds the request:
    - addr = if_req.addr, size = MSIZE4, strobe = 0, data = 0.
  - `dresp.addr_ok`, `dresp.data_ok` and `dresp.data` go to the granted requester only; non-granted responses are all-zero.
  - Fetch data = `dresp.data[63:32]` if `if_req.addr[2]`, else `[31:0]`.
- **Transitions:**
  - ADDR, addr_ok && data_ok → IDLE.
  - ADDR, addr_ok only → DATA.
  - ADDR, granted valid dropped before addr_ok → IDLE (abort; `dreq.valid` is already 0 that cycle).
  - DATA, data_ok → IDLE.
  - DATA ignores requester valid. Once addr_ok has been given, the transaction always completes.
- **Priority (fixed build):** ptw > mem > fetch.
- **Reset mid-transaction:**
  - State goes to IDLE and `grant` to 0.
  - Any in-flight `dresp` is dropped.
  - The core is reset together with the arbiter, so no requester waits on a dropped response.

## Timing
- **Reset values:** `grant` = 0, `busy` = 0, `dreq.valid` = 0, all `*_resp` fields = 0, rr pointer = mem-first.
- **Arbitration latency:** valid at cycle t in IDLE → `dreq.valid` = 1 at t+1.
- **Response path:** addr_ok/data_ok/data are combinational, same cycle as `dresp`.
- **Turnaround:** one IDLE bubble after every data_ok; the next grant cannot be issued in the data_ok cycle.
- **Request hold:** requesters keep valid and fields stable until data_ok. The arbiter does not register request fields.
- **Simultaneous valids:** resolved only in IDLE. A request arriving during ADDR/DATA waits; it is never lost while valid stays high.

## Configuration
- **`MEM_ARB_RR_EN` defined:**
  - ptw stays strictly highest priority.
  - mem and fetch alternate via a 1-bit last-winner pointer, updated on each mem/fetch grant.
  - When both are valid, the one not granted last wins.
- **`MEM_ARB_RR_EN` undefined:** fixed priority ptw > mem > fetch, and the pointer logic is absent.

## Test plan
- **Single fetch, addr 0x8000_0004:**
  - `dreq` = {valid 1, addr 0x8000_0004, size MSIZE4, strobe 0} at t+1.
  - `dresp.data` = 0x1111_2222_3333_4444 with data_ok → `if_resp.data` = 0x1111_2222, `grant` = 3'b100, IDLE next cycle.
- **ptw, mem and fetch all valid in the same cycle:**
  - Grant order is ptw, then mem, then fetch.
  - Exactly one IDLE bubble between transactions.
  - `ptw_resp` data never appears on `mem_resp`/`if_resp`.
- **mem store with addr_ok and data_ok in the same cycle:**
  - Goes ADDR → IDLE directly; `mem_resp.data_ok` = 1 for exactly 1 cycle.
- **Abort:** mem valid drops in ADDR before addr_ok → IDLE next cycle, `grant` = 0, no response asserted.
- **Reset:** reset asserted in DATA → next cycle `busy` = 0, `grant` = 0, `dreq.valid` = 0; a later `dresp.data_ok` = 1 is ignored.
- **Starvation check, mem and fetch held valid for 4 transactions:**
  - With `MEM_ARB_RR_EN`: grants are mem, fetch, mem, fetch.
  - Without it: mem ×4.
